seg7_scan_driver: RTL and testbench

- Downstream consumer of the stopwatch's 16-bit packed-BCD count (4 nibbles, MSD in [15:12]).
- Time-multiplexes the 4 digits onto one shared segment bus with one-hot digit enables, suitable for a 4-digit common-anode board display.
- Captures the input once per scan frame so the shown value never tears mid-frame.
- Performs leading-zero blanking and invalid-nibble indication.

---
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver: per-frame value capture, leading-zero blanking,
// dash for non-BCD nibbles. Optional blinking is compiled in with SEG7_BLINK_EN.
module seg7_scan_driver #(
  parameter int REFRESH_DIV    = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b1,
  parameter int BLINK_FRAMES   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        en,
  input  logic [3:0]  dp_mask,
  input  logic        blink,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   frame_bcd;
  logic [3:0]    frame_dp;
  logic          slot_tick;
  logic          capture;
  logic          blink_dark;

  assign slot_tick = (presc == PRESC_LAST);
  assign capture   = slot_tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      idx        <= 2'd0;
      frame_bcd  <= 16'h0000;
      frame_dp   <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      presc <= slot_tick ? '0 : presc + 1'b1;
      if (slot_tick) idx <= idx + 2'd1;
      // Latch only at the 3->0 wrap so a frame never mixes two input values
      if (capture) begin
        frame_bcd <= bcd_in;
        frame_dp  <= dp_mask;
      end
      frame_tick <= capture;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (capture) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_dark = blink && blink_phase;
`else
  logic unused_blink;
  assign unused_blink = blink | (BLINK_FRAMES < 1);
  assign blink_dark   = 1'b0;
`endif

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  logic [3:0] nib;
  logic       blank;
  logic [3:0] an_l;
  logic [6:0] seg_l;
  logic       dp_l;

  always_comb begin
    nib   = frame_bcd[{idx, 2'b00} +: 4];
    blank = 1'b0;
    case (idx)
      2'd3:    blank = LZ_BLANK && (frame_bcd[15:12] == 4'd0);
      2'd2:    blank = LZ_BLANK && (frame_bcd[15:8] == 8'd0);
      2'd1:    blank = LZ_BLANK && (frame_bcd[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
    an_l  = 4'b0001 << idx;
    seg_l = decode(nib);
    dp_l  = frame_dp[idx];
    if (!en || blink_dark) begin
      an_l  = 4'b0000;
      seg_l = 7'h00;
      dp_l  = 1'b0;
    end else if (blank) begin
      // A blanked digit keeps its anode on only to show a requested decimal point
      seg_l = 7'h00;
      if (!dp_l) an_l = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= {4{SEG_ACTIVE_LOW}};
      seg <= {7{SEG_ACTIVE_LOW}};
      dp  <= SEG_ACTIVE_LOW;
    end else begin
      an  <= an_l ^ {4{SEG_ACTIVE_LOW}};
      seg <= seg_l ^ {7{SEG_ACTIVE_LOW}};
      dp  <= dp_l ^ SEG_ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed steps plus random stimulus against a frame-level model.
module tb_seg7_scan_driver;
  localparam int RD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RD;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK_BUILT = 1'b1;
`else
  localparam bit BLINK_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic        en = 1'b1;
  logic [3:0]  dp_mask = 4'h0;
  logic        blink = 1'b0;
  logic [6:0]  seg, seg_b;
  logic        dp, dp_b;
  logic [3:0]  an, an_b;
  logic        ft, ft_b;

  always #5 clk = ~clk;

  seg7_scan_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b1), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .en(en), .dp_mask(dp_mask), .blink(blink),
    .seg(seg), .dp(dp), .an(an), .frame_tick(ft));

  seg7_scan_driver #(.REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1'b1), .LZ_BLANK(1'b0), .BLINK_FRAMES(BF)) dut_nolz (
    .clk(clk), .reset(reset), .bcd_in(bcd_in), .en(en), .dp_mask(dp_mask), .blink(blink),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_tick(ft_b));

  int tests = 0;
  int fails = 0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Model state: cycles since reset release, shown frame value, captured frame count
  int          n = 0;
  logic [15:0] m_bcd = 16'h0000;
  logic [3:0]  m_dp = 4'h0;
  int          m_frames = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Active-low {an, seg, dp} for digit position d of frame value v
  function automatic logic [11:0] expect_out(input bit lz, input int d, input logic [15:0] v,
                                             input logic [3:0] dpm, input bit dark);
    int         msd;
    logic [3:0] a;
    logic [6:0] s;
    logic       p;
    msd = 0;
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] != 4'd0) msd = i;
    a = 4'b0001 << d;
    s = dec_tab[v[d*4 +: 4]];
    p = dpm[d];
    if (dark) begin
      a = 4'b0000; s = 7'h00; p = 1'b0;
    end else if (lz && d > msd) begin
      s = 7'h00;
      if (!p) a = 4'b0000;
    end
    return {~a, ~s, ~p};
  endfunction

  task automatic tick();
    logic [11:0] e1, e0;
    logic [15:0] b;
    logic [3:0]  m;
    bit          eft, dark, cap;
    b = bcd_in;
    m = dp_mask;
    if (reset) begin
      @(posedge clk);
      n = 0; m_bcd = 16'h0000; m_dp = 4'h0; m_frames = 0;
      e1 = 12'hFFF; e0 = 12'hFFF; eft = 1'b0;
    end else begin
      dark = !en || (BLINK_BUILT && blink && ((m_frames / BF) % 2 == 1));
      e1   = expect_out(1'b1, (n / RD) % 4, m_bcd, m_dp, dark);
      e0   = expect_out(1'b0, (n / RD) % 4, m_bcd, m_dp, dark);
      cap  = (n % FRAME) == FRAME - 1;
      eft  = cap;
      @(posedge clk);
      if (cap) begin m_bcd = b; m_dp = m; m_frames++; end
      n++;
    end
    #1;
    check("scan_lz", {3'b0, ft, an, seg, dp}, {3'b0, eft, e1});
    check("scan_nolz", {3'b0, ft_b, an_b, seg_b, dp_b}, {3'b0, eft, e0});
  endtask

  task automatic run_until_an(input bit use_b, input logic [3:0] target, input string tag);
    int k;
    k = 0;
    while ((use_b ? an_b : an) !== target && k < 2 * FRAME) begin tick(); k++; end
    check(tag, 16'(use_b ? an_b : an), 16'(target));
  endtask

  initial begin
    int ftc;
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("reset_an", 16'(an), 16'h000F);
      check("reset_seg", 16'(seg), 16'h007F);
    end

    bcd_in = 16'h1234;
    reset  = 1'b0;
    tick();
    check("first_an", 16'(an), 16'h000E);
    check("first_seg", 16'(seg), 16'h0040);
    ftc = 0;
    repeat (2 * FRAME) begin tick(); if (ft) ftc++; end
    check("ft_per_2frames", 16'(ftc), 16'd2);
    run_until_an(1'b0, 4'b1110, "wait_d0"); check("d0_4", 16'(seg), 16'h0019);
    run_until_an(1'b0, 4'b1101, "wait_d1"); check("d1_3", 16'(seg), 16'h0030);
    run_until_an(1'b0, 4'b1011, "wait_d2"); check("d2_2", 16'(seg), 16'h0024);
    run_until_an(1'b0, 4'b0111, "wait_d3"); check("d3_1", 16'(seg), 16'h0079);

    bcd_in = 16'h0005;
    repeat (2 * FRAME) tick();
    run_until_an(1'b0, 4'b1110, "wait_5"); check("lz_5", 16'(seg), 16'h0012);
    run_until_an(1'b1, 4'b0111, "wait_nolz3"); check("nolz_d3_0", 16'(seg_b), 16'h0040);

    bcd_in = 16'h1111;
    repeat (2 * FRAME) tick();
    run_until_an(1'b0, 4'b1101, "wait_mid");
    bcd_in = 16'h2222;
    run_until_an(1'b0, 4'b1011, "wait_mid_d2"); check("mid_d2_old", 16'(seg), 16'h0079);
    run_until_an(1'b0, 4'b0111, "wait_mid_d3"); check("mid_d3_old", 16'(seg), 16'h0079);
    run_until_an(1'b0, 4'b1110, "wait_new_d0"); check("new_d0", 16'(seg), 16'h0024);

    bcd_in = 16'h00A0;
    repeat (2 * FRAME) tick();
    run_until_an(1'b0, 4'b1101, "wait_dash"); check("dash_d1", 16'(seg), 16'h003F);
    run_until_an(1'b0, 4'b1110, "wait_a0");   check("dash_d0", 16'(seg), 16'h0040);
    en = 1'b0;
    tick();
    check("en_off_an", 16'(an), 16'h000F);
    repeat (9) tick();
    en = 1'b1;
    repeat (FRAME) tick();

    bcd_in  = 16'h0007;
    dp_mask = 4'b0100;
    repeat (2 * FRAME) tick();
    run_until_an(1'b0, 4'b1011, "wait_dp_blank");
    check("dp_blank_seg", 16'(seg), 16'h007F);
    check("dp_blank_dp", 16'(dp), 16'h0000);
    dp_mask = 4'h0;

    repeat (400) begin
      for (int i = 0; i < 4; i++)
        bcd_in[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      dp_mask = 4'($urandom_range(0, 15));
      en      = ($urandom_range(0, 7) != 0);
      blink   = ($urandom_range(0, 1) == 1);
      tick();
    end

    en = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midscan_reset_an", 16'(an), 16'h000F);
    reset = 1'b0;

    bcd_in = 16'h1234;
    blink  = 1'b1;
    repeat (10 * FRAME) tick();
    blink = 1'b0;
    repeat (4 * FRAME) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
